// File: rtl/taxi_pkg.sv
// Shared taxi-meter types and BCD constants used by the fare stage and the display driver.
package taxi_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHold = 2'd2
  } fare_state_e;

  localparam logic [15:0] BCD_MAX  = 16'h9999;
  localparam logic [15:0] BCD_ZERO = 16'h0000;

  localparam logic [15:0] BASE_FARE_DFLT = 16'h0008;
  localparam logic [15:0] RATE_DFLT      = 16'h0002;
  localparam logic [15:0] RATE_DBL_DFLT  = 16'h0004;

endpackage

// File: rtl/bcd_add16.sv
// Combinational 4-digit BCD adder with decimal carry out of the top digit.
module bcd_add16 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] sum_o,
  output logic        carry_o
);

  logic [4:0] raw [4];
  logic [4:0] carry;

  always_comb begin
    carry    = '0;
    sum_o    = '0;
    for (int i = 0; i < 4; i++) begin
      raw[i] = {1'b0, a_i[4*i +: 4]} + {1'b0, b_i[4*i +: 4]} + {4'b0000, carry[i]};
      if (raw[i] > 5'd9) begin
        sum_o[4*i +: 4] = 4'(raw[i] - 5'd10);
        carry[i+1]      = 1'b1;
      end else begin
        sum_o[4*i +: 4] = raw[i][3:0];
        carry[i+1]      = 1'b0;
      end
    end
    carry_o = carry[4];
  end

endmodule

// File: rtl/fare_calc.sv
// Taxi-meter fare accumulator: IDLE/RUN/HOLD trip control with saturating 4-digit BCD fare.
// Optional waiting-time charge is built when FARE_WAIT_CHARGE_EN is defined.
module fare_calc
  import taxi_pkg::*;
#(
  parameter logic [15:0] BASE_FARE = BASE_FARE_DFLT,
  parameter logic [15:0] RATE      = RATE_DFLT,
  parameter logic [15:0] RATE_DBL  = RATE_DBL_DFLT
`ifdef FARE_WAIT_CHARGE_EN
  ,
  parameter int unsigned WAIT_CYCLES = 16,
  parameter logic [15:0] WAIT_RATE   = 16'h0001
`endif
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [11:0] distance_i,
  input  logic        en_i,
  input  logic        double_i,
  output logic [15:0] fare_o,
  output logic        fare_valid_o,
  output logic        running_o,
  output logic        overflow_o
);

  fare_state_e state_q, state_d;
  logic [15:0] fare_q, fare_d;
  logic        ovf_q, ovf_d;
  logic        start_q;
  logic [11:0] dist_q;

  logic        step;
  logic        start_rise;
  logic        charge;
  logic [15:0] add_val;
  logic [15:0] sum;
  logic        carry;

  assign step       = (distance_i != dist_q);
  assign start_rise = start_i && !start_q;

`ifdef FARE_WAIT_CHARGE_EN
  localparam logic [15:0] WaitLast = 16'(WAIT_CYCLES - 1);
  logic [15:0] wait_q, wait_d;
`endif

  bcd_add16 u_add (
    .a_i    (fare_q),
    .b_i    (add_val),
    .sum_o  (sum),
    .carry_o(carry)
  );

  always_comb begin
    state_d = state_q;
    fare_d  = fare_q;
    ovf_d   = ovf_q;
    charge  = 1'b0;
    add_val = BCD_ZERO;
`ifdef FARE_WAIT_CHARGE_EN
    wait_d  = '0;
`endif
    unique case (state_q)
      StIdle, StHold: begin
        if (start_rise) begin
          state_d = StRun;
          fare_d  = BASE_FARE;
          ovf_d   = 1'b0;
        end
      end
      StRun: begin
        // Trip end wins over any step seen in the same cycle.
        if (!start_i) begin
          state_d = StHold;
        end else if (step && en_i) begin
          charge  = 1'b1;
          add_val = double_i ? RATE_DBL : RATE;
        end
`ifdef FARE_WAIT_CHARGE_EN
        else if (!step && (wait_q == WaitLast)) begin
          charge  = 1'b1;
          add_val = WAIT_RATE;
        end
        if (start_i && !step && (wait_q != WaitLast)) begin
          wait_d = wait_q + 16'd1;
        end
`endif
      end
      default: state_d = StIdle;
    endcase

    if (charge) begin
      fare_d = carry ? BCD_MAX : sum;
      if (carry) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      fare_q  <= BCD_ZERO;
      ovf_q   <= 1'b0;
      start_q <= 1'b0;
      dist_q  <= '0;
`ifdef FARE_WAIT_CHARGE_EN
      wait_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      fare_q  <= fare_d;
      ovf_q   <= ovf_d;
      start_q <= start_i;
      dist_q  <= distance_i;
`ifdef FARE_WAIT_CHARGE_EN
      wait_q  <= wait_d;
`endif
    end
  end

  assign fare_o       = fare_q;
  assign overflow_o   = ovf_q;
  assign running_o    = (state_q == StRun);
  assign fare_valid_o = (state_q == StHold);

endmodule

// File: tb/tb_fare_calc.sv
// Self-checking bench for fare_calc: decimal-integer trip model plus directed literal checks.
module tb_fare_calc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [11:0] distance = 12'h000;
  logic        en = 1'b0;
  logic        dbl = 1'b0;

  logic [15:0] fare [2];
  logic        fvalid [2];
  logic        running [2];
  logic        ovf [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fare_calc u_dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .start_i     (start),
    .distance_i  (distance),
    .en_i        (en),
    .double_i    (dbl),
    .fare_o      (fare[0]),
    .fare_valid_o(fvalid[0]),
    .running_o   (running[0]),
    .overflow_o  (ovf[0])
  );

  fare_calc #(
    .BASE_FARE(16'h9998)
`ifdef FARE_WAIT_CHARGE_EN
    ,
    .WAIT_CYCLES(4)
`endif
  ) u_sat (
    .clk_i       (clk),
    .reset_i     (reset),
    .start_i     (start),
    .distance_i  (distance),
    .en_i        (en),
    .double_i    (dbl),
    .fare_o      (fare[1]),
    .fare_valid_o(fvalid[1]),
    .running_o   (running[1]),
    .overflow_o  (ovf[1])
  );

  // ---------------- model: trip fare as plain decimal integers ----------------
  int m_base [2] = '{8, 9998};
`ifdef FARE_WAIT_CHARGE_EN
  int m_wait_n [2] = '{16, 4};
  int m_still [2];
`endif
  int m_fare [2];
  bit m_run [2];
  bit m_done [2];
  bit m_ovf [2];
  bit m_prev_start;
  int m_prev_dist;

  function automatic int bcd3_to_int(input logic [11:0] d);
    return int'(d[11:8]) * 100 + int'(d[7:4]) * 10 + int'(d[3:0]);
  endfunction

  function automatic logic [15:0] int_to_bcd4(input int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  task automatic m_add(input int i, input int amt);
    if (m_fare[i] + amt > 9999) begin
      m_fare[i] = 9999;
      m_ovf[i]  = 1'b1;
    end else begin
      m_fare[i] = m_fare[i] + amt;
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_fare[i] = 0; m_run[i] = 0; m_done[i] = 0; m_ovf[i] = 0;
`ifdef FARE_WAIT_CHARGE_EN
        m_still[i] = 0;
`endif
      end
      m_prev_start = 0;
      m_prev_dist  = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit moved;
        moved = (bcd3_to_int(distance) != m_prev_dist);
        if (m_run[i]) begin
          if (!start) begin
            m_run[i] = 0; m_done[i] = 1;
          end else if (moved && en) begin
            m_add(i, dbl ? 4 : 2);
          end
`ifdef FARE_WAIT_CHARGE_EN
          if (start && !moved) begin
            m_still[i]++;
            if (m_still[i] == m_wait_n[i]) begin
              m_add(i, 1);
              m_still[i] = 0;
            end
          end else begin
            m_still[i] = 0;
          end
`endif
        end else if (start && !m_prev_start) begin
          m_run[i] = 1; m_done[i] = 0; m_fare[i] = m_base[i]; m_ovf[i] = 0;
`ifdef FARE_WAIT_CHARGE_EN
          m_still[i] = 0;
`endif
        end
      end
      m_prev_start = start;
      m_prev_dist  = bcd3_to_int(distance);
    end
  end

  // ---------------- compare process: every cycle, both instances ----------------
  task automatic cmp(input string name, input int i, input logic [15:0] got,
                     input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s dut%0d @%0t: got %h want %h", name, i, $time, got, want);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < 2; i++) begin
        cmp("model_fare", i, fare[i], int_to_bcd4(m_fare[i]));
        cmp("model_running", i, 16'(running[i]), 16'(m_run[i]));
        cmp("model_valid", i, 16'(fvalid[i]), 16'(m_done[i]));
        cmp("model_ovf", i, 16'(ovf[i]), 16'(m_ovf[i]));
      end
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  task automatic drive(input bit s, input logic [11:0] d, input bit e, input bit db);
    @(negedge clk);
    start = s; distance = d; en = e; dbl = db;
    @(posedge clk);
    #2;
  endtask

  task automatic lit(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    lit("reset_fare", fare[0], 16'h0000);

    drive(1, 12'h000, 0, 0);
    lit("start_base", fare[0], 16'h0008);
    lit("start_running", 16'(running[0]), 16'h0001);
    lit("sat_base", fare[1], 16'h9998);
    drive(1, 12'h001, 0, 0);
    drive(1, 12'h002, 0, 0);
    drive(1, 12'h003, 0, 0);
    lit("en0_steps", fare[0], 16'h0008);

    drive(1, 12'h004, 1, 0);
    lit("rate_step1", fare[0], 16'h0010);
    lit("sat_9999", fare[1], 16'h9999);
    lit("sat_ovf", 16'(ovf[1]), 16'h0001);
    drive(1, 12'h005, 1, 0);
    lit("rate_step2", fare[0], 16'h0012);
    lit("sat_hold_9999", fare[1], 16'h9999);

    drive(1, 12'h009, 0, 0);
    drive(1, 12'h010, 1, 1);
    lit("dbl_step1", fare[0], 16'h0016);
    drive(1, 12'h011, 1, 1);
    lit("dbl_carry", fare[0], 16'h0020);
    drive(1, 12'h012, 1, 1);
    lit("dbl_step3", fare[0], 16'h0024);

    drive(0, 12'h013, 1, 0);
    lit("stop_no_charge", fare[0], 16'h0024);
    lit("stop_valid", 16'(fvalid[0]), 16'h0001);
    lit("stop_running", 16'(running[0]), 16'h0000);
    drive(0, 12'h014, 1, 1);
    lit("hold_frozen", fare[0], 16'h0024);
    lit("hold_ovf_sticky", 16'(ovf[1]), 16'h0001);

    drive(1, 12'h015, 1, 0);
    lit("restart_base_only", fare[0], 16'h0008);
    lit("restart_valid", 16'(fvalid[0]), 16'h0000);
    lit("restart_ovf_clr", 16'(ovf[1]), 16'h0000);
    drive(1, 12'h016, 1, 0);
    drive(1, 12'h017, 1, 0);
    lit("pre_reset", fare[0], 16'h0012);

    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    lit("async_fare", fare[0], 16'h0000);
    lit("async_running", 16'(running[0]), 16'h0000);
    lit("async_valid", 16'(fvalid[0]), 16'h0000);
    lit("async_ovf", 16'(ovf[1]), 16'h0000);
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    drive(1, 12'h000, 0, 0);
    lit("post_reset_base", fare[0], 16'h0008);
    repeat (8) drive(1, 12'h000, 1, 0);
`ifdef FARE_WAIT_CHARGE_EN
    lit("idle_run_default", fare[0], 16'h0008);
    lit("idle_run_wait4", fare[1], 16'h9999);
`else
    lit("idle_run_frozen", fare[0], 16'h0008);
    lit("idle_run_sat", fare[1], 16'h9998);
`endif
    drive(0, 12'h000, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fare_calc.md
Name: fare_calc

Overview:
- Taxi-meter stage directly downstream of the BCD distance counter.
- Consumes its 3-digit BCD distance plus the en (past base distance) and double (long-haul rate) flags.
- Accumulates a 4-digit BCD fare per trip for the display driver.
- Trip control: an IDLE/RUN/HOLD state machine driven by the same start level that gates the distance counter.

Parameters:
- BASE_FARE, 16'h0008, BCD flag-fall loaded at trip start.
- RATE, 16'h0002, BCD charge per distance step while en=1 and double=0.
- RATE_DBL, 16'h0004, BCD charge per distance step while en=1 and double=1.
- WAIT_CYCLES, 16, consecutive no-movement RUN cycles per waiting charge (feature only).
- WAIT_RATE, 16'h0001, BCD waiting charge (feature only).

Ports:
- clk, input, 1, system clock, rising edge.
- reset, input, 1, asynchronous, active-high reset.
- start, input, 1, trip-active level; same signal that drives the distance counter.
- distance, input, 12, BCD distance from the upstream counter; digits [11:8] [7:4] [3:0].
- en, input, 1, upstream flag: base distance exceeded.
- double, input, 1, upstream flag: double-rate zone.
- fare, output, 16, BCD fare, 4 digits.
- fare_valid, output, 1, high in HOLD: trip ended, fare final.
- running, output, 1, high in RUN.
- overflow, output, 1, sticky: fare saturated at 9999.

Behaviour:
- Reset (async, active-high) values:
  - state=IDLE; fare=16'h0000; fare_valid=0; running=0; overflow=0.
  - Internal: start_q=0, dist_q=0, wait counter=0.
  - Reset mid-trip aborts the trip, with no residual charge.
- Registers updated every clock:
  - start_q <= start.
  - dist_q <= distance.
  - Step event: step = (distance != dist_q). This includes the 999->000 wrap.
- IDLE: on start=1 && start_q=0 -> RUN, fare <= BASE_FARE, overflow <= 0.
- RUN:
  - start=0 -> HOLD. No charge is applied that cycle, even if step=1.
  - Otherwise, if step && en: fare <= fare + (double ? RATE_DBL : RATE).
  - step with en=0 adds nothing.
- HOLD:
  - fare is frozen and fare_valid=1.
  - start=1 && start_q=0 -> RUN, reloading BASE_FARE and clearing overflow. This begins a new trip.
- Latency:
  - fare reflects a distance change on the clock edge after the cycle in which distance differs from dist_q. Total: one clock.
  - running and fare_valid are registered and change on the same edge as the state.
- Arithmetic:
  - 4-digit BCD add with decimal carry per digit (digit sum >9 -> subtract 10, carry 1).
  - Carry out of the top digit saturates fare to 16'h9999 and sets overflow. It stays set until the next trip start or reset.
  - Further charges at 9999 keep fare 9999.
  - Inputs are assumed to be legal BCD; non-BCD digits are undefined behaviour, and the bench does not drive them.
- Simultaneous events:
  - A start rising edge on the same cycle as a step loads BASE_FARE only.
  - en and double are sampled on the charging cycle only.

Optional Feature:
- Macro: FARE_WAIT_CHARGE_EN.
- Defined:
  - In RUN, a wait counter increments on each cycle with step=0 and clears on step or on leaving RUN.
  - On reaching WAIT_CYCLES-1, the counter wraps to 0 and WAIT_RATE is added, with the same saturation rule.
  - A step charge and a wait charge never coincide, because step clears the counter.
- Undefined: no wait counter is built; fare changes only on steps and trip start.

Decomposition:
- Shared package taxi_pkg:
  - state enum {IDLE, RUN, HOLD} as a 2-bit encoding.
  - BCD constants BCD_MAX=16'h9999 and BCD_ZERO.
  - Default BASE_FARE, RATE and RATE_DBL constants, shared with the display driver.
- One sub-module: bcd_add16, a combinational 4-digit BCD adder with carry-out. Reusable for the meter's other BCD totals.

Test Plan:
- Reset asserted mid-RUN with fare=0012 -> fare=0000, state IDLE, all flags 0 immediately (asynchronously).
- start rises, distance steps 000->003 with en=0 -> fare=0008 throughout; running=1.
- Continue steps 003->005 with en=1, double=0 -> fare 0010 then 0012, each one clock after the distance change.
- Steps 009->012 with en=1, double=1 -> fare +0004 per step, crossing digit carry 0016->0020->0024.
- start falls on the same cycle as a step -> no charge, fare_valid=1, fare frozen. start rises again -> fare=0008, fare_valid=0.
- BASE_FARE=16'h9998, RATE=2, one en step -> fare=9999, overflow=1; a further step keeps 9999. With FARE_WAIT_CHARGE_EN and WAIT_CYCLES=4, 8 idle RUN cycles -> +0002.
